// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: the master issues operations and takes results,
// the slave is the ALU.
interface alu_seq_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             zout;
   logic             nout;
   logic             vout;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, cout, zout, nout, vout
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, cout, zout, nout, vout
   );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with registered result/flags, valid/ready on both sides and bit-serial shifts.
// Define ALU_SEQ_MUL_EN to build the shift-add multiplier for op 110 (otherwise it acts as CLR).
module alu_seq #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input logic   clk,
   input logic   rst,
   alu_seq_if.slave bus
);
   localparam int unsigned CW = SHW + 1;

   localparam logic [2:0] OpPass = 3'b000;
   localparam logic [2:0] OpNor  = 3'b001;
   localparam logic [2:0] OpAdd  = 3'b010;
   localparam logic [2:0] OpSub  = 3'b011;
   localparam logic [2:0] OpShl  = 3'b100;
   localparam logic [2:0] OpShr  = 3'b101;
`ifdef ALU_SEQ_MUL_EN
   localparam logic [2:0] OpMul  = 3'b110;
`endif

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e           state;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] sh_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH:0]   alu_r;
   logic             alu_v;
   logic [WIDTH:0]   sh_step;
   logic [WIDTH-1:0] sh_src;
   logic             shl;
   logic [SHW-1:0]   k;
   logic             is_shift;
   logic [WIDTH:0]   fin_r;
   logic             fin_v;
   logic             fin_go;

`ifdef ALU_SEQ_MUL_EN
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_step;
`endif

   always_comb begin
      k        = bus.b[SHW-1:0];
      is_shift = (bus.op == OpShl) || (bus.op == OpShr);
      alu_v    = 1'b0;
      case (bus.op)
         OpPass:  alu_r = {1'b0, bus.a};
         OpNor:   alu_r = {1'b0, ~(bus.a | bus.b)};
         OpAdd: begin
            alu_r = {1'b0, bus.a} + {1'b0, bus.b};
            alu_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_r[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OpSub: begin
            // Top bit of the (WIDTH+1)-bit difference is the borrow.
            alu_r = {1'b0, bus.a} - {1'b0, bus.b};
            alu_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_r[WIDTH-1] != bus.a[WIDTH-1]);
         end
         default: alu_r = '0;
      endcase

      sh_src  = (state == StIdle) ? bus.a : sh_q;
      shl     = (state == StIdle) ? (bus.op == OpShl) : (op_q == OpShl);
      sh_step = shl ? {sh_src, 1'b0} : {sh_src[0], 1'b0, sh_src[WIDTH-1:1]};

`ifdef ALU_SEQ_MUL_EN
      acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

      fin_go = 1'b0;
      fin_r  = alu_r;
      fin_v  = alu_v;
      case (state)
         StIdle: begin
            if (bus.in_valid) begin
               if (is_shift) begin
                  fin_v = 1'b0;
                  if (k == '0) begin
                     fin_go = 1'b1;
                     fin_r  = {1'b0, bus.a};
                  end else if (k == SHW'(1)) begin
                     fin_go = 1'b1;
                     fin_r  = sh_step;
                  end
`ifdef ALU_SEQ_MUL_EN
               end else if (bus.op == OpMul) begin
                  fin_go = 1'b0;
`endif
               end else begin
                  fin_go = 1'b1;
               end
            end
         end
         StBusy: begin
            fin_v  = 1'b0;
            fin_go = (cnt_q == CW'(1));
            fin_r  = sh_step;
`ifdef ALU_SEQ_MUL_EN
            if (op_q == OpMul) begin
               fin_r = {|acc_step[2*WIDTH-1:WIDTH], acc_step[WIDTH-1:0]};
            end
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= StIdle;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.result    <= '0;
         bus.cout      <= 1'b0;
         bus.zout      <= 1'b0;
         bus.nout      <= 1'b0;
         bus.vout      <= 1'b0;
         op_q          <= '0;
         sh_q          <= '0;
         cnt_q         <= '0;
`ifdef ALU_SEQ_MUL_EN
         acc_q         <= '0;
         mcand_q       <= '0;
         mplier_q      <= '0;
`endif
      end else begin
         if (fin_go) begin
            bus.result    <= fin_r[WIDTH-1:0];
            bus.cout      <= fin_r[WIDTH];
            bus.zout      <= (fin_r[WIDTH-1:0] == '0);
            bus.nout      <= fin_r[WIDTH-1];
            bus.vout      <= fin_v;
            bus.out_valid <= 1'b1;
            bus.in_ready  <= 1'b0;
            state         <= StDone;
         end
         case (state)
            StIdle: begin
               if (bus.in_valid) begin
                  op_q         <= bus.op;
                  bus.in_ready <= 1'b0;
                  if (!fin_go) begin
                     // First shift step happens at accept, so k-1 steps remain.
                     state <= StBusy;
                     sh_q  <= sh_step[WIDTH-1:0];
                     cnt_q <= CW'(k) - CW'(1);
`ifdef ALU_SEQ_MUL_EN
                     if (bus.op == OpMul) begin
                        acc_q    <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, bus.a};
                        mplier_q <= bus.b;
                        cnt_q    <= CW'(WIDTH);
                     end
`endif
                  end
               end
            end
            StBusy: begin
               if (!fin_go) begin
                  sh_q  <= sh_step[WIDTH-1:0];
                  cnt_q <= cnt_q - CW'(1);
`ifdef ALU_SEQ_MUL_EN
                  acc_q    <= acc_step;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
`endif
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver queues expected responses, the monitor checks them.
module tb_alu_seq;
   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_NOR  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_SHL  = 3'b100;
   localparam logic [2:0] OP_SHR  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_CLR  = 3'b111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(8))  bus8 ();
   alu_seq_if #(.WIDTH(16)) bus16 ();

   alu_seq #(.WIDTH(8))  dut   (.clk(clk), .rst(rst), .bus(bus8));
   alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   // flg packs {cout, zout, nout, vout}
   typedef struct {
      string      name;
      logic [7:0] res;
      logic [3:0] flg;
      int         cycles;
      int         hold;
      int         acc;
   } item_t;

   item_t q[$];
   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;
   int hs_cyc = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   initial begin : monitor
      item_t cur;
      bit    active;
      int    hold;
      active = 1'b0;
      hold   = 0;
      bus8.out_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (rst || !bus8.out_valid) continue;
         if (!active) begin
            if (q.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_out_valid: result 0x%0h with no operation pending",
                        bus8.result);
               continue;
            end
            cur    = q.pop_front();
            active = 1'b1;
            hold   = cur.hold;
            chk({cur.name, "_result_flags"},
                {bus8.result, bus8.cout, bus8.zout, bus8.nout, bus8.vout}, {cur.res, cur.flg});
            chk({cur.name, "_cycles"}, cyc - cur.acc + 1, cur.cycles);
         end else begin
            chk({cur.name, "_stable"},
                {bus8.result, bus8.cout, bus8.zout, bus8.nout, bus8.vout}, {cur.res, cur.flg});
         end
         if (hold > 0) begin
            bus8.out_ready = 1'b0;
            chk({cur.name, "_in_ready_held_low"}, bus8.in_ready, 1'b0);
            hold--;
         end else begin
            bus8.out_ready = 1'b1;
            hs_cyc = cyc + 1;
            active = 1'b0;
         end
      end
   end

   task automatic issue(input string nm, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] res, input logic [3:0] flg,
                        input int cycles, input int hold);
      item_t it;
      int    waited;
      @(negedge clk);
      bus8.in_valid = 1'b1;
      bus8.op = op;
      bus8.a  = a;
      bus8.b  = b;
      waited  = 0;
      while (!bus8.in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!bus8.in_ready) begin
         total_cnt++;
         $display("FAIL %s_accept: in_ready stayed 0 for %0d cycles, required 1", nm, waited);
         bus8.in_valid = 1'b0;
         return;
      end
      it.name   = nm;
      it.res    = res;
      it.flg    = flg;
      it.cycles = cycles;
      it.hold   = hold;
      it.acc    = cyc + 1;
      chk({nm, "_accept_after_handshake"}, it.acc > hs_cyc, 1'b1);
      q.push_back(it);
      @(posedge clk);
      #1 bus8.in_valid = 1'b0;
   endtask

   task automatic run16(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res, input logic [3:0] flg);
      int waited;
      @(negedge clk);
      bus16.in_valid = 1'b1;
      bus16.op = OP_ADD;
      bus16.a  = a;
      bus16.b  = b;
      waited   = 0;
      while (!bus16.in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      chk({nm, "_in_ready"}, bus16.in_ready, 1'b1);
      @(posedge clk);
      #1 bus16.in_valid = 1'b0;
      @(negedge clk);
      chk({nm, "_out_valid"}, bus16.out_valid, 1'b1);
      chk({nm, "_result_flags"},
          {bus16.result, bus16.cout, bus16.zout, bus16.nout, bus16.vout}, {res, flg});
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : main
      int waited;
      bit seen;
      bus8.in_valid = 1'b0;
      bus8.op = '0;
      bus8.a  = '0;
      bus8.b  = '0;
      bus16.in_valid  = 1'b0;
      bus16.op = '0;
      bus16.a  = '0;
      bus16.b  = '0;
      bus16.out_ready = 1'b1;

      repeat (2) @(negedge clk);
      chk("reset_in_ready", bus8.in_ready, 1'b1);
      chk("reset_outputs", {bus8.out_valid, bus8.result, bus8.cout, bus8.zout, bus8.nout,
                            bus8.vout}, '0);
      rst = 1'b0;

      // Abort a 7-cycle SHL with reset in its third cycle.
      @(negedge clk);
      bus8.in_valid = 1'b1;
      bus8.op = OP_SHL;
      bus8.a  = 8'h81;
      bus8.b  = 8'h07;
      @(posedge clk);
      #1 bus8.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midshl_reset_in_ready", bus8.in_ready, 1'b1);
      chk("midshl_reset_outputs", {bus8.out_valid, bus8.result, bus8.cout, bus8.zout,
                                   bus8.nout, bus8.vout}, '0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus8.out_valid) seen = 1'b1;
      end
      chk("midshl_no_out_valid", seen, 1'b0);

      issue("add_ff_01",  OP_ADD,  8'hFF, 8'h01, 8'h00, 4'b1100, 1, 0);
      issue("add_7f_01",  OP_ADD,  8'h7F, 8'h01, 8'h80, 4'b0011, 1, 0);
      issue("add_80_80",  OP_ADD,  8'h80, 8'h80, 8'h00, 4'b1101, 1, 0);
      issue("sub_03_05",  OP_SUB,  8'h03, 8'h05, 8'hFE, 4'b1010, 1, 0);
      issue("sub_80_01",  OP_SUB,  8'h80, 8'h01, 8'h7F, 4'b0001, 1, 0);
      issue("sub_05_05",  OP_SUB,  8'h05, 8'h05, 8'h00, 4'b0100, 1, 0);
      issue("nor_f0_0f",  OP_NOR,  8'hF0, 8'h0F, 8'h00, 4'b0100, 1, 0);
      issue("pass_a5",    OP_PASS, 8'hA5, 8'h00, 8'hA5, 4'b0010, 1, 0);
      issue("clr",        OP_CLR,  8'h5A, 8'h33, 8'h00, 4'b0100, 1, 0);
      issue("shl_81_k3",  OP_SHL,  8'h81, 8'h03, 8'h08, 4'b0000, 3, 0);
      issue("shr_81_k1",  OP_SHR,  8'h81, 8'h01, 8'h40, 4'b1000, 1, 0);
      issue("shl_5a_k0",  OP_SHL,  8'h5A, 8'h00, 8'h5A, 4'b0000, 1, 0);
      issue("shr_01_k2",  OP_SHR,  8'h01, 8'h02, 8'h00, 4'b0100, 2, 0);
      issue("shr_80_k7",  OP_SHR,  8'h80, 8'h0F, 8'h01, 4'b0000, 7, 0);
      issue("shl_03_k7",  OP_SHL,  8'h03, 8'h07, 8'h80, 4'b1010, 7, 0);
`ifdef ALU_SEQ_MUL_EN
      issue("mul_10_11",  OP_MUL,  8'h10, 8'h11, 8'h10, 4'b1000, 9, 0);
`else
      issue("mul_10_11",  OP_MUL,  8'h10, 8'h11, 8'h00, 4'b0100, 1, 0);
`endif
      issue("bp_add",     OP_ADD,  8'h12, 8'h34, 8'h46, 4'b0000, 1, 5);
      issue("bp_next",    OP_PASS, 8'h3C, 8'hFF, 8'h3C, 4'b0000, 1, 0);

      waited = 0;
      while ((q.size() != 0 || bus8.out_valid) && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      chk("scoreboard_drained", q.size(), 0);

      run16("w16_add_ffff_0001", 16'hFFFF, 16'h0001, 16'h0000, 4'b1100);
      run16("w16_add_7fff_0001", 16'h7FFF, 16'h0001, 16'h8000, 4'b0011);
      run16("w16_add_00ff_0001", 16'h00FF, 16'h0001, 16'h0100, 4'b0000);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
